// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: FSM state type,
// write-back opcode and instruction field positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_RESP = 3'd4
  } seq_state_t;

  // Only this opcode writes its result back into the register file
  localparam logic [2:0] OPC_WB = 3'b011;

  // Instruction layout: regw[15:13] reg1[12:10] reg2[9:7] func[6:3] opcode[2:0]
  localparam int REGW_MSB = 15;
  localparam int REGW_LSB = 13;
  localparam int REG1_MSB = 12;
  localparam int REG1_LSB = 10;
  localparam int REG2_MSB = 9;
  localparam int REG2_LSB = 7;
  localparam int FUNC_MSB = 6;
  localparam int FUNC_LSB = 3;
  localparam int OPC_MSB  = 2;
  localparam int OPC_LSB  = 0;

endpackage

// File: rtl/seq_inst_fifo.sv
// Instruction buffer for the issue sequencer. Wrap-around pointers carry
// one extra bit so full and empty are distinguishable. flush clears it.
module seq_inst_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  assign w_push_ok = push && !full && !flush;
  assign w_pop_ok  = pop && !empty && !flush;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign rdata = r_mem[r_rptr[AW-1:0]];

  // Pointer update; reset and flush both return the buffer to empty
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate reads
  always_ff @(posedge clk) begin
    if (rst_n && w_push_ok) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Multi-cycle issue controller: buffers instructions, then runs
// READ -> EXEC -> (WB) -> RESP for one instruction at a time.
// Optional retirement counter enabled by defining SEQ_RETIRE_CNT_EN.
module alu_issue_sequencer
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int INST_W     = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] inst_data,
  output logic              inst_ready,
  input  logic              flush,
  output logic [2:0]        rf_rd_addr1,
  output logic [2:0]        rf_rd_addr2,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rf_wr_en,
  output logic [2:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  input  logic              res_ready,
  output logic              busy
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [7:0]        retired_cnt
`endif
);

  seq_state_t r_state;
  seq_state_t w_state_next;

  logic [INST_W-1:0] r_ir;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_zero;

  logic              w_push;
  logic              w_pop;
  logic              w_load_res;
  logic [INST_W-1:0] w_fifo_dout;
  logic              w_full;
  logic              w_empty;

  // Flush beats a simultaneous push; nothing is accepted during reset
  assign w_push = rst_n && inst_valid && !w_full && !flush;

  seq_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (w_push),
    .wdata (inst_data),
    .pop   (w_pop),
    .rdata (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // Next-state logic; pops happen from IDLE or on a RESP handshake
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load_res   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!flush && !w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_READ;
        end
      end
      ST_READ: begin
        w_state_next = flush ? ST_IDLE : ST_EXEC;
      end
      ST_EXEC: begin
        if (flush) begin
          w_state_next = ST_IDLE;
        end else begin
          w_load_res   = 1'b1;
          w_state_next = (r_ir[OPC_MSB:OPC_LSB] == OPC_WB) ? ST_WB : ST_RESP;
        end
      end
      ST_WB: begin
        // The write strobe is already out this cycle, so flush only skips RESP
        w_state_next = flush ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        if (flush) begin
          w_state_next = ST_IDLE;
        end else if (res_ready) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = ST_READ;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Instruction register, loaded on every pop and held until the next one
  always_ff @(posedge clk) begin
    if (!rst_n)     r_ir <= '0;
    else if (w_pop) r_ir <= w_fifo_dout;
  end

  // Result capture while the ALU output is valid in EXEC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_data <= '0;
      r_res_zero <= 1'b0;
    end else if (w_load_res) begin
      r_res_data <= alu_result;
      r_res_zero <= alu_zero;
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [7:0] r_retired;

  // Saturating count of result handshakes; flush leaves it alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if ((r_state == ST_RESP) && res_ready && (r_retired != 8'hFF)) begin
      r_retired <= r_retired + 8'd1;
    end
  end

  assign retired_cnt = rst_n ? r_retired : 8'd0;
`endif

  // Every output is forced to zero while reset is held
  assign inst_ready  = rst_n && !w_full;
  assign rf_rd_addr1 = rst_n ? r_ir[REG1_MSB:REG1_LSB] : 3'd0;
  assign rf_rd_addr2 = rst_n ? r_ir[REG2_MSB:REG2_LSB] : 3'd0;
  assign alu_ctrl    = rst_n ? r_ir[FUNC_MSB:FUNC_LSB] : 4'd0;
  assign rf_wr_addr  = rst_n ? r_ir[REGW_MSB:REGW_LSB] : 3'd0;
  assign rf_wr_en    = rst_n && (r_state == ST_WB);
  assign rf_wr_data  = rst_n ? r_res_data : '0;
  assign res_valid   = rst_n && (r_state == ST_RESP);
  assign res_data    = rst_n ? r_res_data : '0;
  assign res_zero    = rst_n && r_res_zero;
  assign busy        = rst_n && ((r_state != ST_IDLE) || !w_empty);

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Randomized self-checking bench for alu_issue_sequencer with an external
// register-file/ALU environment and an in-order instruction-level model.
module tb_alu_issue_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic        inst_ready;
  logic        flush;
  logic [2:0]  rf_rd_addr1;
  logic [2:0]  rf_rd_addr2;
  logic [3:0]  alu_ctrl;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [7:0]  rf_wr_data;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_zero;
  logic        res_ready;
  logic        busy;
`ifdef SEQ_RETIRE_CNT_EN
  logic [7:0]  retired_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_issue_sequencer #(.FIFO_DEPTH(4), .INST_W(16), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_ready  (inst_ready),
    .flush       (flush),
    .rf_rd_addr1 (rf_rd_addr1),
    .rf_rd_addr2 (rf_rd_addr2),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_zero    (res_zero),
    .res_ready   (res_ready),
    .busy        (busy)
`ifdef SEQ_RETIRE_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  // ALU function table of the external ALU
  function automatic logic [7:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'b0110: alu_f = a + b;
      4'b0111: alu_f = a - b;
      4'b0000: alu_f = a & b;
      4'b0001: alu_f = a | b;
      default: alu_f = a ^ b;
    endcase
  endfunction

  // External register file: read data registered every cycle, write on strobe
  logic [7:0] rf [8];
  logic [7:0] a1_q = 8'd0;
  logic [7:0] a2_q = 8'd0;

  always @(posedge clk) begin
    a1_q <= rf[rf_rd_addr1];
    a2_q <= rf[rf_rd_addr2];
    if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
  end

  assign alu_result = alu_f(alu_ctrl, a1_q, a2_q);
  assign alu_zero   = (alu_result == 8'd0);

  // Reference model: accepted instructions in program order, executed one at a time
  logic [15:0] inst_q [$];
  logic [7:0]  mref [8];
  bit          front_done;
  bit          front_wr_seen;
  logic [7:0]  front_res;
  int          n_hs = 0;
  int          n_wr = 0;
  int          hs_base = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_eval();
    logic [15:0] i;
    if (!front_done) begin
      i = inst_q[0];
      front_res  = alu_f(i[6:3], mref[i[12:10]], mref[i[9:7]]);
      front_done = 1'b1;
    end
  endtask

  task automatic model_flush();
    inst_q.delete();
    front_done    = 1'b0;
    front_wr_seen = 1'b0;
  endtask

  // Monitor: compare writes and results with the model, record accepted pushes
  always @(negedge clk) begin
    logic [15:0] fi;
    if (rst_n) begin
      if (rf_wr_en) begin
        n_wr++;
        if (inst_q.size() == 0) begin
          check_eq("unexp_wr", 1, 0);
        end else begin
          model_eval();
          fi = inst_q[0];
          check_eq("wr_addr", rf_wr_addr, fi[15:13]);
          check_eq("wr_data", rf_wr_data, front_res);
          check_eq("wr_opc", fi[2:0], 3'b011);
          mref[fi[15:13]] = front_res;
          front_wr_seen = 1'b1;
        end
      end
      if (res_valid) begin
        if (inst_q.size() == 0) begin
          check_eq("unexp_res", 1, 0);
        end else if (res_ready) begin
          model_eval();
          fi = inst_q[0];
          check_eq("res", {res_zero, res_data}, {(front_res == 8'd0), front_res});
          check_eq("wb_done", front_wr_seen, (fi[2:0] == 3'b011));
          void'(inst_q.pop_front());
          front_done    = 1'b0;
          front_wr_seen = 1'b0;
          n_hs++;
        end
      end
      if (inst_valid && inst_ready && !flush) inst_q.push_back(inst_data);
    end
  end

  function automatic logic [15:0] rand_inst();
    logic [3:0]  fl [5];
    logic [15:0] v;
    fl = '{4'b0110, 4'b0111, 4'b0000, 4'b0001, 4'b0010};
    v[15:13] = 3'($urandom_range(0, 7));
    v[12:10] = 3'($urandom_range(0, 7));
    v[9:7]   = 3'($urandom_range(0, 7));
    v[6:3]   = fl[$urandom_range(0, 4)];
    v[2:0]   = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'($urandom_range(0, 7));
    return v;
  endfunction

  // All stimulus tasks start and end one time unit after a rising edge
  task automatic send(input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    inst_valid = 1'b1;
    inst_data  = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (inst_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("send_timeout", 0, 1);
    @(posedge clk); #1;
    inst_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && inst_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_one(input logic [15:0] d, input int exp_lat, input logic [7:0] exp_d, input logic exp_z);
    int lat;
    int wr;
    lat = 0;
    wr  = 0;
    res_ready = 1'b1;
    send(d);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rf_wr_en) begin
        wr++;
        check_eq("wr_addr_dir", rf_wr_addr, d[15:13]);
      end
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    check_eq("latency", lat, exp_lat);
    check_eq("wr_cycles", wr, (d[2:0] == 3'b011) ? 1 : 0);
    check_eq("rd_addr1", rf_rd_addr1, d[12:10]);
    check_eq("rd_addr2", rf_rd_addr2, d[9:7]);
    check_eq("alu_ctrl", alu_ctrl, d[6:3]);
    check_eq("res_dir", {res_zero, res_data}, {exp_z, exp_d});
    @(posedge clk); #1;
  endtask

  task automatic rand_phase(input int n);
    int acc;
    int guard;
    bit was_acc;
    acc   = 0;
    guard = 0;
    inst_valid = 1'b0;
    while (acc < n && guard < 20000) begin
      guard++;
      if (!inst_valid && $urandom_range(0, 2) != 0) begin
        inst_valid = 1'b1;
        inst_data  = rand_inst();
      end
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      was_acc = inst_valid && inst_ready;
      @(posedge clk); #1;
      if (was_acc) begin
        acc++;
        inst_valid = 1'b0;
      end
    end
    inst_valid = 1'b0;
    res_ready  = 1'b1;
    if (acc < n) check_eq("rand_timeout", acc, n);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int nacc;
    int hs0;
    int wr0;
    bit a;
    bit seen;

    for (int i = 0; i < 8; i++) begin
      rf[i]   = 8'(i);
      mref[i] = 8'(i);
    end
    rst_n = 1'b0; inst_valid = 1'b0; inst_data = '0; flush = 1'b0; res_ready = 1'b0;
    model_flush();

    // Reset state, during and after reset
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_ctrl", {inst_ready, rf_wr_en, res_valid, busy}, 4'b0000);
    check_eq("rst_data", {rf_rd_addr1, rf_rd_addr2, alu_ctrl, rf_wr_addr, rf_wr_data, res_data, res_zero}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ctrl", {inst_ready, rf_wr_en, res_valid, busy}, 4'b1000);
    check_eq("post_rst_data", {rf_rd_addr1, rf_rd_addr2, alu_ctrl, rf_wr_addr, rf_wr_data, res_data, res_zero}, 0);
`ifdef SEQ_RETIRE_CNT_EN
    check_eq("retired_rst", retired_cnt, 0);
`endif
    @(posedge clk); #1;

    // ADD with write-back: r3+r4 -> r2, latency 5
    run_one(16'h4E33, 5, 8'h07, 1'b0);
    wait_idle();
    // SUB r5-r5, no write-back, latency 4
    run_one(16'h36B8, 4, 8'h00, 1'b1);
    wait_idle();

    // Result held under backpressure, one retirement per handshake
    res_ready = 1'b0;
    hs0 = n_hs;
    send(16'h1BB0);
    send(16'h0508);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("hold_seen", seen, 1);
    for (int k = 0; k < 10; k++) begin
      check_eq("hold", {res_valid, res_zero, res_data}, {1'b1, 1'b0, 8'h0D});
      @(negedge clk);
    end
    @(posedge clk); #1; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("one_retired", n_hs - hs0, 1);
    check_eq("second_res", {res_valid, res_data}, {1'b1, 8'h07});
    @(posedge clk); #1; res_ready = 1'b1;
    wait_idle();

    // Capacity: FIFO plus IR under backpressure
    res_ready = 1'b0;
    hs0 = n_hs;
    nacc = 0;
    inst_valid = 1'b1;
    inst_data = rand_inst();
    repeat (12) begin
      @(negedge clk);
      a = inst_ready;
      @(posedge clk); #1;
      if (a) begin
        nacc++;
        inst_data = rand_inst();
      end
    end
    inst_valid = 1'b0;
    check_eq("bp_accepts", nacc, 5);
    @(negedge clk);
    check_eq("bp_ready_low", {res_valid, inst_ready}, 2'b10);
    @(posedge clk); #1; res_ready = 1'b1;
    @(negedge clk);
    check_eq("hs_ready_before", {res_valid, inst_ready}, 2'b10);
    @(negedge clk);
    check_eq("ready_after_hs", inst_ready, 1);
    @(posedge clk); #1;
    wait_idle();
    check_eq("bp_retired", n_hs - hs0, 5);

    // Flush in EXEC with two queued and a simultaneous push
    res_ready = 1'b1;
    hs0 = n_hs;
    wr0 = n_wr;
    send(16'h4E33);
    send(rand_inst());
    send(rand_inst());
    flush = 1'b1;
    inst_valid = 1'b1;
    inst_data = 16'h4E33;
    @(posedge clk); #1;
    flush = 1'b0;
    inst_valid = 1'b0;
    model_flush();
    @(negedge clk);
    check_eq("flush_exec_state", {busy, res_valid, rf_wr_en, inst_ready}, 4'b0001);
    repeat (8) @(negedge clk);
    check_eq("flush_exec_nowr", n_wr - wr0, 0);
    check_eq("flush_exec_nores", n_hs - hs0, 0);
    @(posedge clk); #1;

    // Flush in WB: the write still lands, no result
    hs0 = n_hs;
    wr0 = n_wr;
    send(16'h4E33);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_flush();
    @(negedge clk);
    check_eq("flush_wb_state", {busy, res_valid}, 2'b00);
    repeat (6) @(negedge clk);
    check_eq("flush_wb_wr", n_wr - wr0, 1);
    check_eq("flush_wb_nores", n_hs - hs0, 0);
    @(posedge clk); #1;

    // Reset asserted during WB
    send(16'h4E33);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_wb", {rf_wr_en, res_valid, inst_ready, busy}, 4'b0000);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_wb_edge", {rf_wr_en, res_valid, inst_ready, busy}, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_flush();
    hs_base = n_hs;
    @(negedge clk);
    check_eq("rst_wb_after", {inst_ready, busy, res_valid, rf_wr_en}, 4'b1000);
`ifdef SEQ_RETIRE_CNT_EN
    check_eq("retired_rst2", retired_cnt, 0);
`endif
    @(posedge clk); #1;

    // Randomized traffic against the model
    rand_phase(60);
`ifdef SEQ_RETIRE_CNT_EN
    check_eq("retired_cnt", retired_cnt, n_hs - hs_base);
    rand_phase(300);
    check_eq("retired_sat", retired_cnt, 255);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
